pulse_batch_counter: RTL and testbench

- Sits directly downstream of the fast-to-slow pulse synchronizer, in the slow_clk domain.
- Counts incoming single-cycle event pulses as tokens.
- Hands tokens to the convolution controller in fixed-size batches over a valid/ready handshake.
- Supports flushing a partial batch and reports token level and overflow.

---
 rtl/pulse_batch_counter.sv | 169 ++++++++++++++++
 tb/tb_pulse_batch_counter.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/pulse_batch_counter.sv
// pulse_batch_counter
//
// Collects single-cycle event pulses from the slow-domain side of the pulse
// synchronizer and passes them on as tokens in fixed-size batches. A
// valid/ready handshake carries each batch to the convolution controller.
// A held partial batch can be flushed out early. The block also reports
// how many tokens it holds and whether any token had to be dropped.
//
// Optional feature (compile-time macro PULSE_TIMEOUT_FLUSH_EN):
//   When the macro is defined, an idle timer runs while the block is in
//   FILL. After TIMEOUT pulse-free cycles it forces a flush of the partial
//   batch. When the macro is not defined, no timer logic is built and
//   TIMEOUT has no effect.
//
// Parameters:
//   CNT_W    width of the token counter, level and out_len
//   BATCH    number of tokens in a full batch (1 .. 2^CNT_W-1)
//   TIMEOUT  number of idle cycles before an automatic flush (macro builds only)
//
// Ports:
//   slow_clk   block clock
//   rstn       asynchronous active-low reset
//   in_pulse   each cycle it is high adds one token
//   flush      requests that held tokens go out as a partial batch
//   out_ready  the consumer takes the offered batch
//   clr_ovf    clears the sticky overflow flag
//   out_valid  a batch is on offer
//   out_len    number of tokens in the offered batch
//   level      tokens held now, including any batch on offer
//   overflow   sticky flag: a token was dropped because the counter was full
module pulse_batch_counter #(
  parameter int CNT_W   = 8,
  parameter int BATCH   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic             slow_clk,
  input  logic             rstn,
  input  logic             in_pulse,
  input  logic             flush,
  input  logic             out_ready,
  input  logic             clr_ovf,
  output logic             out_valid,
  output logic [CNT_W-1:0] out_len,
  output logic [CNT_W-1:0] level,
  output logic             overflow
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_FILL   = 2'd1;
  localparam logic [1:0] S_OFFER  = 2'd2;
  localparam logic [1:0] S_FOFFER = 2'd3;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] BATCH_L = CNT_W'(BATCH);

  if (BATCH < 1 || BATCH >= (1 << CNT_W) || TIMEOUT < 1) begin : g_param_check
    $error("pulse_batch_counter: BATCH or TIMEOUT out of range");
  end

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             out_valid_q, out_valid_d;
  logic [CNT_W-1:0] out_len_q, out_len_d;
  logic             overflow_q, overflow_d;
  logic             flush_pend_q, flush_pend_d;

  logic             accept;
  logic             drop;
  logic             flush_eff;
  logic             pend_now;
  logic             timeout_hit;
  logic [CNT_W-1:0] remain;

`ifdef PULSE_TIMEOUT_FLUSH_EN
  localparam int IDLE_W = $clog2(TIMEOUT + 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);

  logic [IDLE_W-1:0] idle_q, idle_d;

  // The cycle in which the counter reads TIMEOUT-1 is the TIMEOUT-th idle
  // cycle. That cycle acts as a flush, and leaving FILL restarts the count.
  always_comb begin
    timeout_hit = (state_q == S_FILL) && !in_pulse && (idle_q == IDLE_LAST);
    idle_d      = '0;
    if ((state_q == S_FILL) && !in_pulse && !timeout_hit) begin
      idle_d = idle_q + 1'b1;
    end
  end

  always_ff @(posedge slow_clk or negedge rstn) begin
    if (!rstn) begin
      idle_q <= '0;
    end else begin
      idle_q <= idle_d;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    accept    = out_valid_q & out_ready;
    drop      = in_pulse & ~accept & (count_q == CNT_MAX);
    flush_eff = flush | timeout_hit;
    pend_now  = flush_pend_q | flush_eff;

    // An accepted batch is always fully held (out_len <= count), so this
    // subtraction cannot underflow. After an accept the +1 cannot overflow.
    remain  = accept ? (count_q - out_len_q) : count_q;
    count_d = remain + {{(CNT_W-1){1'b0}}, (in_pulse & ~drop)};

    // A drop in the same cycle takes priority over a clear request.
    overflow_d = drop | (overflow_q & ~clr_ovf);

    state_d      = state_q;
    out_valid_d  = out_valid_q;
    out_len_d    = out_len_q;
    flush_pend_d = pend_now;

    // IDLE/FILL re-evaluate every cycle. An offer keeps valid and len
    // unchanged until it is accepted, then re-evaluates on the remainder.
    // flush_pend is always clear in IDLE/FILL, so pend_now equals flush_eff there.
    if ((state_q == S_IDLE) || (state_q == S_FILL) || accept) begin
      if (count_d >= BATCH_L) begin
        state_d     = S_OFFER;
        out_valid_d = 1'b1;
        out_len_d   = BATCH_L;
      end else if ((count_d != '0) && pend_now) begin
        state_d      = S_FOFFER;
        out_valid_d  = 1'b1;
        out_len_d    = count_d;
        flush_pend_d = 1'b0;
      end else if (count_d != '0) begin
        state_d     = S_FILL;
        out_valid_d = 1'b0;
        out_len_d   = '0;
      end else begin
        state_d      = S_IDLE;
        out_valid_d  = 1'b0;
        out_len_d    = '0;
        flush_pend_d = 1'b0;
      end
    end
  end

  always_ff @(posedge slow_clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= S_IDLE;
      count_q      <= '0;
      out_valid_q  <= 1'b0;
      out_len_q    <= '0;
      overflow_q   <= 1'b0;
      flush_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      out_valid_q  <= out_valid_d;
      out_len_q    <= out_len_d;
      overflow_q   <= overflow_d;
      flush_pend_q <= flush_pend_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_len   = out_len_q;
  assign level     = count_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_pulse_batch_counter.sv
// Directed testbench for pulse_batch_counter (CNT_W=8, BATCH=4, TIMEOUT=64).
module tb_pulse_batch_counter;

  logic       slow_clk;
  logic       rstn;
  logic       in_pulse;
  logic       flush;
  logic       out_ready;
  logic       clr_ovf;
  logic       out_valid;
  logic [7:0] out_len;
  logic [7:0] level;
  logic       overflow;

  int vec_cnt = 0;
  int err_cnt = 0;

  pulse_batch_counter #(
    .CNT_W  (8),
    .BATCH  (4),
    .TIMEOUT(64)
  ) dut (
    .slow_clk (slow_clk),
    .rstn     (rstn),
    .in_pulse (in_pulse),
    .flush    (flush),
    .out_ready(out_ready),
    .clr_ovf  (clr_ovf),
    .out_valid(out_valid),
    .out_len  (out_len),
    .level    (level),
    .overflow (overflow)
  );

  initial begin
    slow_clk = 1'b0;
    forever #5 slow_clk = ~slow_clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    assert (obs === exp)
    else begin
      err_cnt++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Checks valid and level. out_len is checked only while a batch is offered.
  task automatic chk(input string tag, input logic v, input int len, input int lvl);
    check({tag, ".valid"}, {31'd0, out_valid}, {31'd0, v});
    if (v) check({tag, ".len"}, {24'd0, out_len}, len);
    check({tag, ".level"}, {24'd0, level}, lvl);
  endtask

  // Advance one clock edge and settle just after it.
  task automatic step();
    @(posedge slow_clk);
    #1;
  endtask

  initial begin
    rstn = 1'b0; in_pulse = 1'b1; flush = 1'b1; out_ready = 1'b1; clr_ovf = 1'b0;

    // Reset held while pulse and flush are driven high: outputs stay cleared.
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst.valid", {31'd0, out_valid}, 0);
      check("rst.len", {24'd0, out_len}, 0);
      check("rst.level", {24'd0, level}, 0);
      check("rst.ovf", {31'd0, overflow}, 0);
    end
    in_pulse = 1'b0; flush = 1'b0; rstn = 1'b1;
    step();
    chk("rst.after", 1'b0, 0, 0);

    // Four pulses with out_ready=1: one-cycle offer of 4, then back to 0.
    in_pulse = 1'b1;
    step(); chk("t1.p1", 1'b0, 0, 1);
    step(); chk("t1.p2", 1'b0, 0, 2);
    step(); chk("t1.p3", 1'b0, 0, 3);
    step(); chk("t1.p4", 1'b1, 4, 4);
    in_pulse = 1'b0;
    step(); chk("t1.acc", 1'b0, 0, 0);
    step(); chk("t1.idle", 1'b0, 0, 0);
    $display("txn t1: 4 pulses -> batch of 4 accepted");

    // Ten pulses with out_ready=0, then two accepts.
    out_ready = 1'b0; in_pulse = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      step();
      if (i == 3) chk("t2.p3", 1'b0, 0, 3);
      if (i == 4) chk("t2.p4", 1'b1, 4, 4);
    end
    chk("t2.p10", 1'b1, 4, 10);
    in_pulse = 1'b0; out_ready = 1'b1;
    step(); chk("t2.acc1", 1'b1, 4, 6);
    step(); chk("t2.acc2", 1'b0, 0, 2);
    out_ready = 1'b0;
    step(); chk("t2.fill", 1'b0, 0, 2);
    $display("txn t2: 10 pulses, two batches accepted, 2 held");

    // Drain the 2 held tokens with a flush.
    flush = 1'b1;
    step(); chk("t3.drain", 1'b1, 2, 2);
    flush = 1'b0; out_ready = 1'b1;
    step(); chk("t3.drained", 1'b0, 0, 0);
    out_ready = 1'b0;

    // Three pulses, then a flush gives a partial offer of 3.
    in_pulse = 1'b1;
    step(); step(); step(); chk("t3.p3", 1'b0, 0, 3);
    in_pulse = 1'b0; flush = 1'b1;
    step(); chk("t3.foffer", 1'b1, 3, 3);
    flush = 1'b0; in_pulse = 1'b1;
    step(); chk("t3.hold", 1'b1, 3, 4);
    in_pulse = 1'b0; out_ready = 1'b1;
    step(); chk("t3.acc", 1'b0, 0, 1);
    out_ready = 1'b0;
    $display("txn t3: partial batch of 3 flushed and accepted, 1 held");

    // From level 1, reach an offer of 4, then accept together with a pulse.
    in_pulse = 1'b1;
    step(); step(); step(); chk("t4.offer", 1'b1, 4, 4);
    out_ready = 1'b1;
    step(); chk("t4.acc_pulse", 1'b0, 0, 1);
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) step();
    chk("t4.lvl6", 1'b1, 4, 6);
    in_pulse = 1'b0; flush = 1'b1;
    step(); chk("t4.flush_offer", 1'b1, 4, 6);
    flush = 1'b0; out_ready = 1'b1;
    step(); chk("t4.pend_foffer", 1'b1, 2, 2);
    step(); chk("t4.empty", 1'b0, 0, 0);
    out_ready = 1'b0;
    $display("txn t4: accept+pulse keeps token; pending flush gives offer of 2");

    // Saturation: the 256th pulse is dropped and sets overflow.
    in_pulse = 1'b1;
    for (int i = 0; i < 255; i++) step();
    chk("t5.full", 1'b1, 4, 255);
    check("t5.ovf0", {31'd0, overflow}, 0);
    step();
    chk("t5.sat", 1'b1, 4, 255);
    check("t5.ovf1", {31'd0, overflow}, 1);
    in_pulse = 1'b0; clr_ovf = 1'b1;
    step(); check("t5.clr", {31'd0, overflow}, 0);
    in_pulse = 1'b1;
    step(); check("t5.drop_wins", {31'd0, overflow}, 1);
    in_pulse = 1'b0;
    step(); check("t5.clr2", {31'd0, overflow}, 0);
    clr_ovf = 1'b0;
    $display("txn t5: saturate at 255, overflow set/cleared, drop beats clear");

    // Asynchronous reset while a batch is offered, asserted mid-cycle.
    #3 rstn = 1'b0;
    #1;
    check("t5.arst.valid", {31'd0, out_valid}, 0);
    check("t5.arst.level", {24'd0, level}, 0);
    #1 rstn = 1'b1;
    $display("txn t5r: async reset clears offer and level");

    // Idle timeout behaviour with two held tokens.
    in_pulse = 1'b1;
    step(); step(); chk("t6.p2", 1'b0, 0, 2);
    in_pulse = 1'b0;
`ifdef PULSE_TIMEOUT_FLUSH_EN
    for (int i = 0; i < 63; i++) step();
    chk("t6.idle63", 1'b0, 0, 2);
    step(); chk("t6.timeout", 1'b1, 2, 2);
    $display("txn t6: timeout flush after 64 idle cycles, len 2");
`else
    for (int i = 0; i < 200; i++) step();
    chk("t6.no_timeout", 1'b0, 0, 2);
    $display("txn t6: no offer after 200 idle cycles");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
